miriscv_data_mem_responder: RTL and testbench

Responder end of the miriscv data memory interface (`data_req/we/be/addr/wdata` → `data_rvalid/rdata`). It serves one outstanding load or store at a time from an internal byte-enabled word RAM, with a fixed base latency plus a per-request extra wait, and signals out-of-range accesses. It sits in the core testbench and the small-SoC top as the data-side memory attached to the memory stage's LSU.

---
 rtl/miriscv_data_mem_responder_pkg.sv | 14 +
 rtl/miriscv_data_mem_responder_if.sv | 25 ++
 rtl/miriscv_data_mem_responder_ram.sv | 32 +++
 rtl/miriscv_data_mem_responder.sv | 110 +++++++++++
 tb/tb_miriscv_data_mem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/miriscv_data_mem_responder_pkg.sv
// Shared types and widths for the miriscv data memory responder.
package miriscv_mem_resp_pkg;

    localparam int XLEN         = 32;
    localparam int EXTRA_WAIT_W = 4;
    localparam int WAIT_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_e;

endpackage

// File: rtl/miriscv_data_mem_responder_if.sv
// Data memory bus between the LSU (master) and the memory responder (slave).
interface miriscv_data_mem_responder_if;
    import miriscv_mem_resp_pkg::*;

    logic                    data_req_i;
    logic                    data_we_i;
    logic [XLEN/8-1:0]       data_be_i;
    logic [XLEN-1:0]         data_addr_i;
    logic [XLEN-1:0]         data_wdata_i;
    logic [EXTRA_WAIT_W-1:0] extra_wait_i;
    logic                    data_rvalid_o;
    logic [XLEN-1:0]         data_rdata_o;
    logic                    data_err_o;

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, extra_wait_i,
        input  data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i, extra_wait_i,
        output data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/miriscv_data_mem_responder_ram.sv
// Word RAM with per-byte write enables and a registered read port.
// The array is deliberately not reset.
module miriscv_data_ram
    import miriscv_mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [XLEN/8-1:0]        be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [XLEN-1:0]          wdata_i,
    output logic [XLEN-1:0]          rdata_o
);

    logic [XLEN-1:0] mem [DEPTH];

    // Single port: enabled access either writes selected lanes or reads the word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < XLEN/8; b++) begin
                    if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/miriscv_data_mem_responder.sv
// miriscv data-side memory responder: one outstanding load/store at a time,
// LATENCY + extra_wait cycles to the response pulse, out-of-range flagging.
// The wait counter holds LATENCY - 1 + 15, so LATENCY must not exceed 17.
module miriscv_data_mem_responder
    import miriscv_mem_resp_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int              DEPTH     = 1024,
    parameter int              LATENCY   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    miriscv_data_mem_responder_if.slave bus
);

    localparam int                    AW     = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] LAT_M1 = WAIT_CNT_W'(LATENCY - 1);
    localparam logic [XLEN:0]         SPAN   = (XLEN+1)'(DEPTH * 4);

    mem_resp_state_e       state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d, cnt_load;
    logic [XLEN-1:0]       offset;
    logic [AW-1:0]         word_idx;
    logic                  in_range, accept, ram_en;
    logic                  we_q, err_q, fresh_q;
    logic [XLEN-1:0]       ram_rdata, hold_q, rdata_q, load_data;

    assign offset   = bus.data_addr_i - BASE_ADDR;
    assign in_range = (bus.data_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign word_idx = offset[AW+1:2];
    assign accept   = (state_q == IDLE) && bus.data_req_i && !rst_i;
    assign ram_en   = accept && in_range;
    assign cnt_load = LAT_M1 + WAIT_CNT_W'(bus.extra_wait_i);

    miriscv_data_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (bus.data_we_i),
        .be_i    (bus.data_be_i),
        .addr_i  (word_idx),
        .wdata_i (bus.data_wdata_i),
        .rdata_o (ram_rdata)
    );

    // State and wait counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, count down (or abort) in WAIT, one-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.data_req_i) begin
                    cnt_d   = cnt_load;
                    state_d = (cnt_load == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.data_req_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                    if (cnt_q == WAIT_CNT_W'(1)) state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request attributes, load hold register and the presented read data.
    // fresh_q marks the cycle right after a load acceptance, when the RAM
    // output register already has the word but the hold register does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            fresh_q <= 1'b0;
            hold_q  <= '0;
            rdata_q <= '0;
        end else begin
            fresh_q <= accept && !bus.data_we_i && in_range;
            if (fresh_q) hold_q <= ram_rdata;
            if (accept) begin
                we_q  <= bus.data_we_i;
                err_q <= !in_range;
                if (!bus.data_we_i && !in_range) hold_q <= '0;
            end
            if (state_q == RESP && !we_q) rdata_q <= load_data;
        end
    end

    // In a load response the data comes straight from the registered RAM
    // output when RESP follows acceptance directly, otherwise from the hold
    // register; outside load responses the last load result is held.
    assign load_data         = fresh_q ? ram_rdata : hold_q;
    assign bus.data_rdata_o  = (state_q == RESP && !we_q) ? load_data : rdata_q;
    assign bus.data_rvalid_o = (state_q == RESP);
    assign bus.data_err_o    = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_miriscv_data_mem_responder.sv
// Directed bench for the data memory responder: DUT A (BASE 0x1000, 64 words,
// LATENCY 1) and DUT B (BASE 0, 1024 words, LATENCY 3) share one stimulus
// bundle; sel routes the request to one of them.
module tb_miriscv_data_mem_responder;
    import miriscv_mem_resp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0, we = 1'b0, sel = 1'b0;
    logic [3:0]  be = 4'h0, ew = 4'h0;
    logic [31:0] addr = 32'h0, wd = 32'h0;

    miriscv_data_mem_responder_if bus_a ();
    miriscv_data_mem_responder_if bus_b ();

    assign bus_a.data_req_i   = req & ~sel;
    assign bus_a.data_we_i    = we;
    assign bus_a.data_be_i    = be;
    assign bus_a.data_addr_i  = addr;
    assign bus_a.data_wdata_i = wd;
    assign bus_a.extra_wait_i = ew;
    assign bus_b.data_req_i   = req & sel;
    assign bus_b.data_we_i    = we;
    assign bus_b.data_be_i    = be;
    assign bus_b.data_addr_i  = addr;
    assign bus_b.data_wdata_i = wd;
    assign bus_b.extra_wait_i = ew;

    miriscv_data_mem_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH(64), .LATENCY(1)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus (bus_a.slave));
    miriscv_data_mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH(1024), .LATENCY(3)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus (bus_b.slave));

    logic        rv, er_w;
    logic [31:0] rd_w;
    assign rv   = sel ? bus_b.data_rvalid_o : bus_a.data_rvalid_o;
    assign rd_w = sel ? bus_b.data_rdata_o  : bus_a.data_rdata_o;
    assign er_w = sel ? bus_b.data_err_o    : bus_a.data_err_o;

    int checks = 0, errors = 0;
    int rv_cnt_a = 0, rv_cnt_b = 0, exp_a = 0, exp_b = 0;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] model [8];

    always @(negedge clk) begin
        if (bus_a.data_rvalid_o === 1'b1) rv_cnt_a++;
        if (bus_b.data_rvalid_o === 1'b1) rv_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request in an IDLE cycle, hold it until rvalid, then drop it
    // and confirm the pulse lasted a single cycle.
    task automatic op(input string tag, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] e,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        logic [31:0] rd;
        logic err;
        req = 1'b1; we = w; be = b; addr = a; wd = d; ew = e; lat = 0;
        do begin
            tick();
            lat++;
        end while (rv !== 1'b1 && lat < 40);
        rd = rd_w;
        err = er_w;
        if (rv !== 1'b1) lat = -1;
        req = 1'b0;
        if (sel) exp_b++; else exp_a++;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_rdata"}, rd, exp_rd);
        tick();
        chk({tag, "_pulse"}, 32'(rv), 32'd0);
    endtask

    // Accept a request, then drop req in the second WAIT cycle.
    task automatic abort_req(input string tag, input logic w, input logic [31:0] a);
        req = 1'b1; we = w; be = 4'hF; addr = a; wd = 32'h0; ew = 4'd4;
        tick();
        chk({tag, "_wait1"}, 32'(rv), 32'd0);
        tick();
        req = 1'b0;
        chk({tag, "_wait2"}, 32'(rv), 32'd0);
        tick();
        chk({tag, "_idle"}, 32'(rv), 32'd0);
    endtask

    initial begin
        int seen;
        logic w;
        logic [2:0] idx;
        logic [3:0] b, e;
        logic [31:0] d, exp_rd;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_rvalid_a", 32'(bus_a.data_rvalid_o), 32'd0);
        chk("rst_rdata_a", bus_a.data_rdata_o, 32'd0);
        chk("rst_err_a", 32'(bus_a.data_err_o), 32'd0);
        chk("rst_rvalid_b", 32'(bus_b.data_rvalid_o), 32'd0);
        chk("rst_rdata_b", bus_b.data_rdata_o, 32'd0);

        // Byte-lane store and readback, address low bits ignored, be=0 no-op.
        op("init_10",   1, 4'hF, 32'h1010, 32'h0000_0000, 4'd0, 1, 0, 32'h0);
        op("st_be0110", 1, 4'h6, 32'h1010, 32'hAABB_CCDD, 4'd0, 1, 0, 32'h0);
        op("ld_be",     0, 4'h0, 32'h1010, 32'h0,         4'd0, 1, 0, 32'h00BB_CC00);
        op("ld_unalgn", 0, 4'h0, 32'h1013, 32'h0,         4'd0, 1, 0, 32'h00BB_CC00);
        op("st_be0",    1, 4'h0, 32'h1010, 32'hFFFF_FFFF, 4'd0, 1, 0, 32'h00BB_CC00);
        op("ld_wait2",  0, 4'h0, 32'h1010, 32'h0,         4'd2, 3, 0, 32'h00BB_CC00);

        // Range boundaries on both sides; rejected stores must not alias.
        op("init_w0",   1, 4'hF, 32'h1000, 32'h1122_3344, 4'd0, 1, 0, 32'h00BB_CC00);
        op("init_w63",  1, 4'hF, 32'h10FC, 32'h5566_7788, 4'd0, 1, 0, 32'h00BB_CC00);
        op("st_oor_hi", 1, 4'hF, 32'h1100, 32'hDEAD_BEEF, 4'd0, 1, 1, 32'h00BB_CC00);
        op("st_oor_lo", 1, 4'hF, 32'h0FFC, 32'hDEAD_BEEF, 4'd1, 2, 1, 32'h00BB_CC00);
        op("ld_w0",     0, 4'h0, 32'h1000, 32'h0,         4'd0, 1, 0, 32'h1122_3344);
        op("ld_w63",    0, 4'h0, 32'h10FC, 32'h0,         4'd0, 1, 0, 32'h5566_7788);
        op("ld_oor_hi", 0, 4'h0, 32'h1100, 32'h0,         4'd0, 1, 1, 32'h0);
        op("ld_w63b",   0, 4'h0, 32'h10FC, 32'h0,         4'd0, 1, 0, 32'h5566_7788);
        op("ld_oor_lo", 0, 4'h0, 32'h0FFC, 32'h0,         4'd3, 4, 1, 32'h0);

        // Aborted load: never answered, then a fresh request right after.
        abort_req("abort1", 1'b0, 32'h1000);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rv === 1'b1) seen++;
        end
        chk("abort1_silent", 32'(seen), 32'd0);
        abort_req("abort2", 1'b0, 32'h1000);
        op("after_abort", 0, 4'h0, 32'h10FC, 32'h0, 4'd0, 1, 0, 32'h5566_7788);

        // Reset during WAIT of a store: no response, outputs cleared, store kept.
        op("ld_pre_rst", 0, 4'h0, 32'h1000, 32'h0, 4'd0, 1, 0, 32'h1122_3344);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h1020; wd = 32'h0BAD_CAFE; ew = 4'd5;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b0;
        chk("rst_mid_rvalid", 32'(bus_a.data_rvalid_o), 32'd0);
        chk("rst_mid_rdata", bus_a.data_rdata_o, 32'd0);
        chk("rst_mid_err", 32'(bus_a.data_err_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rv === 1'b1) seen++;
        end
        chk("rst_mid_silent", 32'(seen), 32'd0);
        op("ld_after_rst", 0, 4'h0, 32'h1020, 32'h0, 4'd0, 1, 0, 32'h0BAD_CAFE);
        last_rd = 32'h0BAD_CAFE;

        // Back-to-back random stream against a word model.
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            op("sb_init", 1, 4'hF, 32'h1040 + 32'(i) * 4, model[i], 4'd0, 1, 0, last_rd);
        end
        for (int i = 0; i < 32; i++) begin
            idx = 3'($urandom_range(0, 7));
            w   = 1'($urandom_range(0, 1));
            b   = 4'($urandom);
            d   = $urandom;
            e   = 4'($urandom_range(0, 3));
            if (w) begin
                exp_rd = last_rd;
                for (int k = 0; k < 4; k++) if (b[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            end else begin
                exp_rd = model[idx];
                last_rd = model[idx];
            end
            op("sb", w, b, 32'h1040 + 32'(idx) * 4 + 32'($urandom_range(0, 3)), d, e,
               1 + int'(e), 0, exp_rd);
        end

        // DUT B: base latency 3, extra waits up to the maximum, back-to-back.
        sel = 1'b1;
        tick();
        op("b_st",     1, 4'hF, 32'h0010, 32'hCAFE_F00D, 4'd0,  3,  0, 32'h0);
        op("b_ld_8",   0, 4'h0, 32'h0010, 32'h0,         4'd5,  8,  0, 32'hCAFE_F00D);
        op("b_b2b",    0, 4'h0, 32'h0010, 32'h0,         4'd0,  3,  0, 32'hCAFE_F00D);
        op("b_ld_max", 0, 4'h0, 32'h0010, 32'h0,         4'd15, 18, 0, 32'hCAFE_F00D);
        op("b_oor",    0, 4'h0, 32'h1000, 32'h0,         4'd0,  3,  1, 32'h0);

        tick();
        chk("rv_count_a", 32'(rv_cnt_a), 32'(exp_a));
        chk("rv_count_b", 32'(rv_cnt_b), 32'(exp_b));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
